// File: rtl/keypad_loader_pkg.sv
// Shared types and helpers for the keypad digit loader: FSM encoding,
// entry-size default and the one-hot key decoder.
package keypad_loader_pkg;

    localparam int unsigned KEY_W              = 10;
    localparam int unsigned BCD_W              = 4;
    localparam int unsigned DIGITS_W           = 2;
    localparam int unsigned MAX_DIGITS_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        STROBE   = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [BCD_W-1:0] digit;
    } bcd_t;

    // valid only when exactly one key bit is set; digit is that bit's index
    function automatic bcd_t onehot_to_bcd(input logic [KEY_W-1:0] key);
        bcd_t        r;
        int unsigned ones;
        r    = '0;
        ones = 0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            if (key[i]) begin
                ones    = ones + 1;
                r.digit = BCD_W'(i);
            end
        end
        r.valid = (ones == 1);
        return r;
    endfunction

endpackage

// File: rtl/keypad_loader_stable_counter.sv
// Saturating stability counter; reach_c flags the sample that brings the
// count up to LIMIT so the caller can transition on that same edge.
module keypad_loader_stable_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    input  logic inc,
    output logic reach_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign reach_c = inc && !restart &&
                     ((9'(count) + 9'd1) >= 9'(LIMIT));

endmodule

// File: rtl/keypad_loader.sv
// Debounces a 10-key keypad and shifts each accepted digit into a timer
// with a single active-low load strobe, tracking digits per entry.
module keypad_loader
    import keypad_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_DIGITS      = MAX_DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [KEY_W-1:0]    keypad,
    input  logic                inhibit,
    input  logic                restart,
    output logic [BCD_W-1:0]    data,
    output logic                load,
    output logic [DIGITS_W-1:0] digits,
    output logic                full
);

    state_t              state;
    logic [KEY_W-1:0]    sync1;
    logic [KEY_W-1:0]    sync2;
    logic [KEY_W-1:0]    latched;
    logic [BCD_W-1:0]    latched_digit;
    bcd_t                dec_c;
    logic                cnt_restart_c;
    logic                cnt_inc_c;
    logic                cnt_reach_c;
    logic                go_strobe_c;
    logic [DIGITS_W-1:0] digits_nxt_c;

    // two-flop synchronizer; nothing downstream looks at raw keypad
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= keypad;
            sync2 <= sync1;
        end
    end

    // one counter serves both stable-press and stable-release timing
    keypad_loader_stable_counter #(
        .LIMIT   (DEBOUNCE_CYCLES)
    ) u_stable (
        .clk     (clk),
        .clear   (clear),
        .restart (cnt_restart_c),
        .inc     (cnt_inc_c),
        .reach_c (cnt_reach_c)
    );

    always_comb begin
        dec_c         = onehot_to_bcd(sync2);
        cnt_restart_c = 1'b1;
        cnt_inc_c     = 1'b0;
        case (state)
            DEBOUNCE: begin
                if (!inhibit && (sync2 == latched)) begin
                    cnt_restart_c = 1'b0;
                    cnt_inc_c     = 1'b1;
                end
            end
            RELEASE: begin
                if (sync2 == '0) begin
                    cnt_restart_c = 1'b0;
                    cnt_inc_c     = 1'b1;
                end
            end
            default: ;
        endcase
        go_strobe_c  = (state == DEBOUNCE) && cnt_inc_c && cnt_reach_c;
        digits_nxt_c = digits;
        if (restart) begin
            digits_nxt_c = '0;
        end else if (go_strobe_c) begin
            digits_nxt_c = digits + DIGITS_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state         <= IDLE;
            load          <= 1'b1;
            data          <= '0;
            digits        <= '0;
            full          <= 1'b0;
            latched       <= '0;
            latched_digit <= '0;
        end else begin
            load   <= 1'b1;
            digits <= digits_nxt_c;
            full   <= (digits_nxt_c == DIGITS_W'(MAX_DIGITS));
            case (state)
                IDLE: begin
                    if (dec_c.valid && !inhibit && !full) begin
                        latched       <= sync2;
                        latched_digit <= dec_c.digit;
                        state         <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (go_strobe_c) begin
                        load  <= 1'b0;
                        data  <= latched_digit;
                        state <= STROBE;
                    end else if (inhibit || (sync2 != latched)) begin
                        state <= RELEASE;
                    end
                end
                STROBE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (cnt_reach_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_loader.sv
// Directed bench for keypad_loader: a table of press scenarios plus
// hand-written sequences for bounce, inhibit, restart and clear timing.
module tb_keypad_loader;

    logic       clk = 1'b0;
    logic       clear;
    logic [9:0] keypad;
    logic       inhibit;
    logic       restart;
    logic [3:0] data;
    logic       load;
    logic [1:0] digits;
    logic       full;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_loader #(
        .DEBOUNCE_CYCLES (4),
        .MAX_DIGITS      (3)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .keypad  (keypad),
        .inhibit (inhibit),
        .restart (restart),
        .data    (data),
        .load    (load),
        .digits  (digits),
        .full    (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] keys;
        logic       inh;
        logic       rst_first;
        int         exp_pulses;
        int         exp_data;
        int         exp_digits;
        int         exp_full;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // hold keys for 'hold' cycles then release for 'rel'; count load-low cycles
    task automatic run_press(input logic [9:0] key, input int hold, input int rel,
                             input logic inh, output int pulses);
        pulses  = 0;
        keypad  = key;
        inhibit = inh;
        for (int i = 0; i < hold + rel; i++) begin
            if (i == hold) begin
                keypad  = '0;
                inhibit = 1'b0;
            end
            tick();
            if (!load) pulses++;
        end
    endtask

    initial begin
        int pulses;

        vecs[0] = '{10'h080, 1'b0, 1'b0, 1, 7, 1, 0};
        vecs[1] = '{10'h012, 1'b0, 1'b0, 0, 7, 1, 0};
        vecs[2] = '{10'h010, 1'b0, 1'b0, 1, 4, 2, 0};
        vecs[3] = '{10'h200, 1'b1, 1'b0, 0, 4, 2, 0};
        vecs[4] = '{10'h002, 1'b0, 1'b1, 1, 1, 1, 0};
        vecs[5] = '{10'h004, 1'b0, 1'b0, 1, 2, 2, 0};
        vecs[6] = '{10'h008, 1'b0, 1'b0, 1, 3, 3, 1};
        vecs[7] = '{10'h020, 1'b0, 1'b0, 0, 3, 3, 1};
        vecs[8] = '{10'h020, 1'b0, 1'b1, 1, 5, 1, 0};

        clear   = 1'b1;
        keypad  = '0;
        inhibit = 1'b0;
        restart = 1'b0;
        tick();
        tick();
        check("reset load", int'(load), 1);
        check("reset data", int'(data), 0);
        check("reset digits", int'(digits), 0);
        check("reset full", int'(full), 0);
        clear = 1'b0;
        tick();
        check("post-reset load", int'(load), 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) begin
                restart = 1'b1;
                tick();
                restart = 1'b0;
                check($sformatf("v%0d restart digits", i), int'(digits), 0);
            end
            run_press(vecs[i].keys, 20, 10, vecs[i].inh, pulses);
            check($sformatf("v%0d pulses", i), pulses, vecs[i].exp_pulses);
            check($sformatf("v%0d data", i), int'(data), vecs[i].exp_data);
            check($sformatf("v%0d digits", i), int'(digits), vecs[i].exp_digits);
            check($sformatf("v%0d full", i), int'(full), vecs[i].exp_full);
        end

        // key 3 bounce: on 2, off 1, on again -- nothing may strobe in that window
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            keypad = (i == 2) ? 10'h000 : 10'h008;
            tick();
            if (!load) pulses++;
        end
        check("bounce window pulses", pulses, 0);
        for (int i = 0; i < 25; i++) begin
            if (i == 15) keypad = '0;
            tick();
        end
        run_press(10'h008, 20, 10, 1'b0, pulses);
        check("post-bounce pulses", pulses, 1);
        check("post-bounce data", int'(data), 3);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart digits", int'(digits), 0);
        check("restart full", int'(full), 0);

        // inhibit raised after the FSM has started debouncing key 6
        pulses  = 0;
        keypad  = 10'h040;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) inhibit = 1'b1;
            if (i == 20) begin
                keypad  = '0;
                inhibit = 1'b0;
            end
            tick();
            if (!load) pulses++;
        end
        check("inhibit mid-debounce pulses", pulses, 0);
        check("inhibit mid-debounce digits", int'(digits), 0);
        check("inhibit mid-debounce data", int'(data), 3);

        // latency plus restart coinciding with the strobe edge
        pulses = 0;
        keypad = 10'h040;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!load) pulses++;
        end
        check("latency early pulses", pulses, 0);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("latency strobe load", int'(load), 0);
        check("restart+strobe data", int'(data), 6);
        check("restart+strobe digits", int'(digits), 0);
        tick();
        check("strobe one cycle load", int'(load), 1);
        check("after strobe digits", int'(digits), 0);
        keypad = '0;
        for (int i = 0; i < 10; i++) tick();

        // clear landing in the middle of a strobe cycle
        keypad = 10'h100;
        for (int i = 0; i < 7; i++) tick();
        check("pre-clear load", int'(load), 0);
        check("pre-clear data", int'(data), 8);
        check("pre-clear digits", int'(digits), 1);
        #2;
        clear = 1'b1;
        #1;
        check("clear load", int'(load), 1);
        check("clear data", int'(data), 0);
        check("clear digits", int'(digits), 0);
        check("clear full", int'(full), 0);
        keypad = '0;
        tick();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        run_press(10'h004, 20, 10, 1'b0, pulses);
        check("post-clear pulses", pulses, 1);
        check("post-clear data", int'(data), 2);
        check("post-clear digits", int'(digits), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
